// File: rtl/branch_predict_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_predict_unit_pkg
// Shared definitions for the front-end branch predictor: prediction-mode
// codes, 2-bit direction counter encodings, init/run FSM encodings and the
// saturating counter update function.
// Ports: none (package).
// ---------------------------------------------------------------------------
package branch_predict_unit_pkg;

   // Direction-table indexing modes
   localparam logic PRED_BIMODAL = 1'b0;
   localparam logic PRED_GSHARE  = 1'b1;

   // 2-bit direction counter states
   typedef enum logic [1:0] {
      SNT = 2'b00,   // strongly not-taken
      WNT = 2'b01,   // weakly not-taken (init value)
      WT  = 2'b10,   // weakly taken
      ST  = 2'b11    // strongly taken
   } ctr_e;

   // Table init sweep / normal operation
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Saturating +1 on taken, -1 on not-taken
   function automatic logic [1:0] sat2(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken) begin
         if (ctr != 2'b11) res = ctr + 2'b01;
         else              res = ctr;
      end else begin
         if (ctr != 2'b00) res = ctr - 2'b01;
         else              res = ctr;
      end
      return res;
   endfunction

endpackage

// File: rtl/branch_predict_unit_return_stack.sv
// ---------------------------------------------------------------------------
// return_stack
// Circular return-address stack. sp points at the next write slot; count
// tracks valid entries (0..DEPTH). Pushing when full overwrites the oldest
// entry. A simultaneous push+pop on a non-empty stack replaces the top.
// Ports:
//   clk, reset  core clock, synchronous active-high reset (sp/count only)
//   push        write push_addr as new top
//   push_addr   return address to store
//   pop         discard the top entry
//   top         current top entry, 32'h0 when empty (combinational)
//   empty       no valid entry (combinational)
// ---------------------------------------------------------------------------
module return_stack #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [31:0] push_addr,
   input  logic        pop,
   output logic [31:0] top,
   output logic        empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] ONE_P  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [PW:0]   ONE_C  = {{PW{1'b0}}, 1'b1};
   localparam logic [PW:0]   ZERO_C = {(PW+1){1'b0}};
   localparam logic [PW:0]   FULL_C = (PW+1)'(DEPTH);

   logic [31:0]   stack_r [DEPTH];
   logic [PW-1:0] sp_r;
   logic [PW:0]   count_r;
   logic [PW-1:0] sp_m1_s;
   logic          has_entry_s;
   logic          do_push_s;
   logic          do_pop_s;
   logic          do_replace_s;

   // Operation decode; push+pop on an empty stack degrades to a plain push
   always_comb begin
      sp_m1_s      = sp_r - ONE_P;
      has_entry_s  = (count_r != ZERO_C);
      do_push_s    = push & ~(pop & has_entry_s);
      do_pop_s     = pop & ~push & has_entry_s;
      do_replace_s = push & pop & has_entry_s;
   end

   // Stack pointer and occupancy; sp wraps naturally as DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         sp_r    <= {PW{1'b0}};
         count_r <= ZERO_C;
      end else if (do_push_s) begin
         sp_r    <= sp_r + ONE_P;
         count_r <= (count_r == FULL_C) ? FULL_C : count_r + ONE_C;
      end else if (do_pop_s) begin
         sp_r    <= sp_m1_s;
         count_r <= count_r - ONE_C;
      end else begin
         sp_r    <= sp_r;
         count_r <= count_r;
      end
   end

   // Entry storage; contents are intentionally not cleared by reset
   always_ff @(posedge clk) begin
      if (!reset && do_push_s) begin
         stack_r[sp_r] <= push_addr;
      end else if (!reset && do_replace_s) begin
         stack_r[sp_m1_s] <= push_addr;
      end else begin
         stack_r[sp_r] <= stack_r[sp_r];
      end
   end

   // Top-of-stack view
   always_comb begin
      if (has_entry_s) top = stack_r[sp_m1_s];
      else             top = 32'h0000_0000;
      empty = ~has_entry_s;
   end

endmodule

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
// Front-end predictor beside decode: 2-bit counter direction table indexed
// bimodally or gshare, non-speculative global history updated at branch
// resolution, return-address stack, init-sweep FSM and branch statistics.
// Ports:
//   clk, reset         core clock, synchronous active-high reset
//   ready              table initialised, predictions valid
//   q_PC               decode PC; q_taken/q_index answer combinationally
//   upd_*              branch resolution from execute (index, outcome, hit)
//   ras_push/_addr     call seen in decode, return address
//   ras_pop            return seen in decode
//   ras_top/ras_empty  predicted return target / stack empty
//   stat_branches/hits saturating resolved/correct counters
// ---------------------------------------------------------------------------
module branch_predict_unit
   import branch_predict_unit_pkg::*;
#(
   parameter int BHT_ADDR_BITS = 4,
   parameter int HIST_BITS     = 4,
   parameter int PRED_MODE     = 1,
   parameter int RAS_DEPTH     = 4,
   parameter int CNT_W         = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     ready,
   input  logic [31:0]              q_PC,
   output logic                     q_taken,
   output logic [BHT_ADDR_BITS-1:0] q_index,
   input  logic                     upd_valid,
   input  logic [BHT_ADDR_BITS-1:0] upd_index,
   input  logic                     upd_taken,
   input  logic                     upd_hit,
   input  logic                     ras_push,
   input  logic [31:0]              ras_push_addr,
   input  logic                     ras_pop,
   output logic [31:0]              ras_top,
   output logic                     ras_empty,
   output logic [CNT_W-1:0]         stat_branches,
   output logic [CNT_W-1:0]         stat_hits
);

   localparam int BHT_SIZE = 1 << BHT_ADDR_BITS;
   localparam logic [BHT_ADDR_BITS-1:0] LAST_IDX = BHT_ADDR_BITS'(BHT_SIZE - 1);
   localparam logic [BHT_ADDR_BITS-1:0] IDX_ONE  = {{(BHT_ADDR_BITS-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]         CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]         CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic                     USE_GSHARE = (PRED_MODE == int'(PRED_GSHARE));

   state_e                   state_r;
   logic [BHT_ADDR_BITS-1:0] sweep_idx_r;
   logic [HIST_BITS-1:0]     ghr_r;
   logic [1:0]               bht_r [BHT_SIZE];
   logic [CNT_W-1:0]         stat_branches_r;
   logic [CNT_W-1:0]         stat_hits_r;
   logic                     run_s;
   logic [BHT_ADDR_BITS-1:0] pc_idx_s;
   logic [BHT_ADDR_BITS-1:0] ghr_ext_s;
   logic [HIST_BITS:0]       ghr_shift_s;
   logic                     pc_unused_s;

   assign run_s       = (state_r == ST_RUN);
   assign pc_unused_s = ^{q_PC[31:BHT_ADDR_BITS+2], q_PC[1:0]};

   // Query path: table index and predicted direction, no update bypass
   always_comb begin
      pc_idx_s  = q_PC[BHT_ADDR_BITS+1:2];
      ghr_ext_s = {BHT_ADDR_BITS{1'b0}};
      ghr_ext_s[HIST_BITS-1:0] = ghr_r;
      if (USE_GSHARE) q_index = pc_idx_s ^ ghr_ext_s;
      else            q_index = pc_idx_s;
      q_taken = run_s & bht_r[q_index][1];
   end

   // Init sweep FSM: one entry per cycle, then RUN until the next reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_INIT;
         sweep_idx_r <= {BHT_ADDR_BITS{1'b0}};
      end else begin
         case (state_r)
            ST_INIT: begin
               sweep_idx_r <= sweep_idx_r + IDX_ONE;
               if (sweep_idx_r == LAST_IDX) state_r <= ST_RUN;
               else                         state_r <= ST_INIT;
            end
            ST_RUN: begin
               state_r     <= ST_RUN;
               sweep_idx_r <= sweep_idx_r;
            end
            default: begin
               state_r     <= ST_INIT;
               sweep_idx_r <= {BHT_ADDR_BITS{1'b0}};
            end
         endcase
      end
   end

   // Direction table: init writes during sweep, saturating training in RUN
   always_ff @(posedge clk) begin
      if (!reset && !run_s) begin
         bht_r[sweep_idx_r] <= WNT;
      end else if (!reset && upd_valid) begin
         bht_r[upd_index] <= sat2(bht_r[upd_index], upd_taken);
      end else begin
         bht_r[upd_index] <= bht_r[upd_index];
      end
   end

   // Shift register form that also works for a one-bit history
   assign ghr_shift_s = {ghr_r, upd_taken};

   // Global history, advanced only by resolved branches
   always_ff @(posedge clk) begin
      if (reset)                 ghr_r <= {HIST_BITS{1'b0}};
      else if (run_s && upd_valid) ghr_r <= ghr_shift_s[HIST_BITS-1:0];
      else                       ghr_r <= ghr_r;
   end

   // Saturating branch statistics, frozen while the table initialises
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_branches_r <= {CNT_W{1'b0}};
         stat_hits_r     <= {CNT_W{1'b0}};
      end else if (run_s && upd_valid) begin
         if (stat_branches_r != CNT_MAX) stat_branches_r <= stat_branches_r + CNT_ONE;
         else                            stat_branches_r <= stat_branches_r;
         if (upd_hit && stat_hits_r != CNT_MAX) stat_hits_r <= stat_hits_r + CNT_ONE;
         else                                   stat_hits_r <= stat_hits_r;
      end else begin
         stat_branches_r <= stat_branches_r;
         stat_hits_r     <= stat_hits_r;
      end
   end

   assign ready         = run_s;
   assign stat_branches = stat_branches_r;
   assign stat_hits     = stat_hits_r;

   return_stack #(
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push & run_s),
      .push_addr (ras_push_addr),
      .pop       (ras_pop & run_s),
      .top       (ras_top),
      .empty     (ras_empty)
   );

endmodule
